// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: word RAM at low addresses plus an MMIO
// block (cycle counter, GPIO, compare register, sticky match/IRQ status) at the top.
module dmem_responder #(
  parameter int unsigned P_DATA_WIDTH      = 32,
  parameter int unsigned P_DMEM_ADDR_WIDTH = 11,
  parameter int unsigned P_MMIO_BASE       = 11'h600
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_dmem_we,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] i_dmem_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_dmem_wdata,
  output logic [P_DATA_WIDTH-1:0]      o_dmem_rdata,
  output logic [P_DATA_WIDTH-1:0]      o_gpio,
  output logic                         o_timer_irq
);

  localparam int unsigned LP_AW        = P_DMEM_ADDR_WIDTH;
  localparam int unsigned LP_IDX_W     = P_DMEM_ADDR_WIDTH - 2;
  localparam int unsigned LP_RAM_DEPTH = P_MMIO_BASE / 4;
  localparam logic [LP_AW-1:0] LP_BASE = LP_AW'(P_MMIO_BASE);
  localparam logic [LP_AW-1:0] LP_MMIO_SPAN = LP_AW'(16);

  typedef enum logic [1:0] {
    REG_CYCLE  = 2'd0,
    REG_GPIO   = 2'd1,
    REG_CMP    = 2'd2,
    REG_STATUS = 2'd3
  } mmio_reg_e;

  logic [P_DATA_WIDTH-1:0] r_ram [LP_RAM_DEPTH];
  logic [P_DATA_WIDTH-1:0] r_cycle;
  logic [P_DATA_WIDTH-1:0] r_gpio;
  logic [P_DATA_WIDTH-1:0] r_cmp;
  logic                    r_match;
  logic                    r_ien;

  logic                w_is_ram;
  logic [LP_IDX_W-1:0] w_ram_idx;
  logic [LP_AW-1:0]    w_off;
  logic                w_mmio_hit;
  mmio_reg_e           w_reg;
  logic                w_wr_gpio;
  logic                w_wr_cmp;
  logic                w_wr_status;
  logic                w_cycle_hit;

  assign w_is_ram    = (i_dmem_addr < LP_BASE);
  assign w_ram_idx   = i_dmem_addr[LP_AW-1:2];
  assign w_off       = i_dmem_addr - LP_BASE;
  assign w_mmio_hit  = !w_is_ram && (w_off < LP_MMIO_SPAN);
  assign w_reg       = mmio_reg_e'(w_off[3:2]);
  assign w_wr_gpio   = i_dmem_we && w_mmio_hit && (w_reg == REG_GPIO);
  assign w_wr_cmp    = i_dmem_we && w_mmio_hit && (w_reg == REG_CMP);
  assign w_wr_status = i_dmem_we && w_mmio_hit && (w_reg == REG_STATUS);
  // Compare uses the pre-write CMP, so a CMP write only affects later cycles.
  assign w_cycle_hit = (r_cycle == r_cmp);

  always_ff @(posedge i_clk) begin
    if (i_dmem_we && w_is_ram) begin
      r_ram[w_ram_idx] <= i_dmem_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycle <= '0;
      r_gpio  <= '0;
      r_cmp   <= '1;
      r_match <= 1'b0;
      r_ien   <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      if (w_wr_gpio) begin
        r_gpio <= i_dmem_wdata;
      end
      if (w_wr_cmp) begin
        r_cmp <= i_dmem_wdata;
      end
      if (w_wr_status) begin
        r_ien <= i_dmem_wdata[1];
      end
      // A match in the same cycle as a write-1-to-clear keeps MATCH set.
      if (w_cycle_hit) begin
        r_match <= 1'b1;
      end else if (w_wr_status && i_dmem_wdata[0]) begin
        r_match <= 1'b0;
      end
    end
  end

  always_comb begin
    o_dmem_rdata = '0;
    if (w_is_ram) begin
      o_dmem_rdata = r_ram[w_ram_idx];
    end else if (w_mmio_hit) begin
      case (w_reg)
        REG_CYCLE:  o_dmem_rdata = r_cycle;
        REG_GPIO:   o_dmem_rdata = r_gpio;
        REG_CMP:    o_dmem_rdata = r_cmp;
        REG_STATUS: o_dmem_rdata = {{(P_DATA_WIDTH-2){1'b0}}, r_ien, r_match};
        default:    o_dmem_rdata = '0;
      endcase
    end
  end

  assign o_gpio      = r_gpio;
  assign o_timer_irq = r_match & r_ien;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expectations from a flat
// memory-map model; a negedge monitor pops and compares against the DUT outputs.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_we;
  logic [10:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic [31:0] o_gpio;
  logic        o_irq;

  dmem_responder #(
    .P_DATA_WIDTH(32),
    .P_DMEM_ADDR_WIDTH(11),
    .P_MMIO_BASE(11'h600)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_dmem_we(i_we),
    .i_dmem_addr(i_addr),
    .i_dmem_wdata(i_wdata),
    .o_dmem_rdata(o_rdata),
    .o_gpio(o_gpio),
    .o_timer_irq(o_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    bit          chk_rd;
    logic [31:0] gpio;
    bit          irq;
    string       tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: the memory map as plain variables.
  logic [31:0] m_ram [384];
  bit          m_known [384];
  logic [31:0] m_cyc, m_gpio, m_cmp;
  bit          m_match, m_ien;

  function automatic logic [31:0] model_read(input int unsigned addr);
    int unsigned a;
    a = addr & 32'h7FC;
    if (a < 32'h600) return m_ram[a / 4];
    case (a - 32'h600)
      0:  return m_cyc;
      4:  return m_gpio;
      8:  return m_cmp;
      12: return {30'd0, m_ien, m_match};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_known(input int unsigned addr);
    int unsigned a;
    a = addr & 32'h7FC;
    if (a < 32'h600) return m_known[a / 4];
    return 1'b1;
  endfunction

  task automatic model_tick(input bit we, input int unsigned addr, input logic [31:0] wd);
    int unsigned a;
    bit hit;
    a = addr & 32'h7FC;
    hit = (m_cyc == m_cmp);
    if (we) begin
      if (a < 32'h600) begin
        m_ram[a / 4]   = wd;
        m_known[a / 4] = 1'b1;
      end else begin
        case (a - 32'h600)
          4:  m_gpio = wd;
          8:  m_cmp = wd;
          12: begin
            m_ien = wd[1];
            if (wd[0]) m_match = 1'b0;
          end
          default: ;
        endcase
      end
    end
    if (hit) m_match = 1'b1;
    m_cyc = m_cyc + 32'd1;
  endtask

  task automatic push_exp(input int unsigned addr, input string tag);
    exp_t e;
    e.rdata  = model_read(addr);
    e.chk_rd = model_known(addr);
    e.gpio   = m_gpio;
    e.irq    = m_match & m_ien;
    e.tag    = tag;
    q.push_back(e);
  endtask

  task automatic step(input bit we, input int unsigned addr, input logic [31:0] wd,
                      input string tag);
    i_we    = we;
    i_addr  = addr[10:0];
    i_wdata = wd;
    push_exp(addr, tag);
    @(posedge clk);
    model_tick(we, addr, wd);
    #1;
  endtask

  // Reset is raised just after an edge and checked before the next one.
  task automatic do_reset(input int unsigned addr, input string tag);
    i_rst   = 1'b1;
    i_we    = 1'b0;
    i_addr  = addr[10:0];
    i_wdata = 32'd0;
    m_cyc = 32'd0; m_gpio = 32'd0; m_cmp = 32'hFFFF_FFFF; m_match = 1'b0; m_ien = 1'b0;
    push_exp(addr, tag);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_rd) begin
          checks++;
          if (o_rdata !== e.rdata) begin
            errors++;
            $display("FAIL %s rdata addr=%h got %h exp %h", e.tag, i_addr, o_rdata, e.rdata);
          end
        end
        checks++;
        if (o_gpio !== e.gpio) begin
          errors++;
          $display("FAIL %s gpio got %h exp %h", e.tag, o_gpio, e.gpio);
        end
        checks++;
        if (o_irq !== e.irq) begin
          errors++;
          $display("FAIL %s irq got %b exp %b", e.tag, o_irq, e.irq);
        end
      end
    end
  end

  initial begin : stim
    int unsigned a;
    int unsigned guard;
    logic [31:0] wd;
    for (int i = 0; i < 384; i++) m_known[i] = 1'b0;
    i_rst = 1'b1; i_we = 1'b0; i_addr = '0; i_wdata = '0;
    @(posedge clk);
    #1;
    do_reset(32'h600, "reset_state");
    do_reset(32'h608, "reset_cmp");

    for (int i = 0; i < 384; i++) step(1'b1, i * 4, $urandom, "ram_init");

    step(1'b1, 32'h010, 32'hDEAD_BEEF, "ram_wr_old");
    step(1'b0, 32'h010, 32'd0, "ram_rd");
    step(1'b0, 32'h013, 32'd0, "ram_rd_unaligned");
    step(1'b1, 32'h5FC, 32'h1234_5678, "ram_last_wr");
    step(1'b0, 32'h5FC, 32'd0, "ram_last_rd");
    step(1'b1, 32'h610, 32'hFFFF_FFFF, "mmio_hole_wr");
    step(1'b0, 32'h610, 32'd0, "mmio_hole_rd");
    step(1'b0, 32'h7FC, 32'd0, "mmio_top_rd");
    step(1'b0, 32'h5FC, 32'd0, "ram_last_keep");

    do_reset(32'h600, "cyc_reset");
    for (int i = 0; i < 10; i++) step(1'b0, 32'h600, 32'd0, "cyc_count");
    step(1'b1, 32'h600, 32'h5555_5555, "cyc_wr_ignored");
    step(1'b0, 32'h602, 32'd0, "cyc_after_wr");

    do_reset(32'h60C, "tmr_reset");
    step(1'b1, 32'h608, 32'd20, "tmr_cmp_wr");
    step(1'b1, 32'h60C, 32'd2, "tmr_ien_wr");
    for (int i = 0; i < 24; i++) step(1'b0, 32'h60C, 32'd0, "tmr_match");
    step(1'b1, 32'h60C, 32'd2, "tmr_wr0_keep");
    step(1'b0, 32'h60C, 32'd0, "tmr_keep_rd");
    step(1'b1, 32'h60C, 32'd3, "tmr_clear");
    step(1'b0, 32'h60C, 32'd0, "tmr_cleared");
    step(1'b1, 32'h608, m_cyc + 32'd3, "tmr_cmp_near");
    guard = 0;
    while (m_cyc != m_cmp && guard < 10) begin
      step(1'b0, 32'h60C, 32'd0, "tmr_wait");
      guard++;
    end
    checks++;
    if (guard >= 10) begin
      errors++;
      $display("FAIL tmr_collision_setup got %0d exp <10", guard);
    end
    step(1'b1, 32'h60C, 32'd3, "tmr_collision");
    step(1'b0, 32'h60C, 32'd0, "tmr_set_wins");
    step(1'b0, 32'h60C, 32'd0, "tmr_set_wins2");

    step(1'b1, 32'h604, 32'hA5A5_0F0F, "gpio_wr");
    step(1'b0, 32'h604, 32'd0, "gpio_rd");
    do_reset(32'h010, "rst_ram_keep");
    step(1'b0, 32'h604, 32'd0, "rst_gpio");

    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 4) a = $urandom_range(0, 32'h5FF);
      else if (r < 9) a = 32'h600 + $urandom_range(0, 31);
      else a = $urandom_range(0, 32'h7FF);
      wd = $urandom;
      if ((a & 32'h7FC) == 32'h608 && $urandom_range(0, 1) == 1) wd = m_cyc + $urandom_range(1, 6);
      if ($urandom_range(0, 99) == 0) do_reset(a, "rnd_reset");
      else step($urandom_range(0, 1) == 1, a, wd, "rnd");
    end

    i_we = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the pipeline's MEM-stage data memory interface.
- Accepts write-enable, byte address and write data from the MEM stage, and returns read data in the same cycle; the MEM/WB register samples that data on the next edge.
- Maps a word RAM at low addresses and a small MMIO block at the top of the address space: free-running cycle counter, GPIO output register, compare register, sticky match/IRQ status.

Parameters:
- P_DATA_WIDTH, 32, data word width; only 32 is supported.
- P_DMEM_ADDR_WIDTH, 11, byte-address width of the interface.
- P_MMIO_BASE, 11'h600, first MMIO byte address. Must be word aligned and a multiple of 16. RAM depth = P_MMIO_BASE/4 words (384 by default).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_dmem_we  input  1  write enable from MEM stage.
- i_dmem_addr  input  P_DMEM_ADDR_WIDTH  byte address from MEM stage.
- i_dmem_wdata  input  P_DATA_WIDTH  write data from MEM stage.
- o_dmem_rdata  output  P_DATA_WIDTH  combinational read data for i_dmem_addr.
- o_gpio  output  P_DATA_WIDTH  GPIO register contents.
- o_timer_irq  output  1  timer interrupt, level.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Register reset values on i_rst: CYCLE=0, GPIO=0 (so o_gpio=0), CMP=32'hFFFF_FFFF, STATUS=0 (so o_timer_irq=0).
- RAM contents are not reset.
- o_dmem_rdata is purely combinational, so its value after reset depends on the RAM or MMIO decode.
- Addressing: word access only; i_dmem_addr[1:0] are ignored. There are no byte or halfword lanes.
- Decode: addr < P_MMIO_BASE selects RAM word addr[AW-1:2]. addr >= P_MMIO_BASE selects MMIO; offset = addr - P_MMIO_BASE.
- RAM read: zero-latency, combinational from the array.
- RAM write: committed on the rising edge when i_dmem_we=1.
- Same-cycle read and write to one address: o_dmem_rdata shows the old value that cycle and the new value from the next cycle.
- MMIO map, word offset:
  - 0x0 CYCLE: read-only; writes ignored.
  - 0x4 GPIO: read/write.
  - 0x8 CMP: read/write.
  - 0xC STATUS: bit0 MATCH (sticky, write-1-to-clear), bit1 IEN (read/write); bits 31:2 read 0.
  - Any offset >= 0x10 reads 0; writes there are ignored.
- CYCLE: increments by 1 every cycle out of reset; wraps 32'hFFFF_FFFF -> 0.
- CYCLE read: returns the pre-increment value for the current cycle.
- MATCH set: MATCH <= 1 on the edge where the current CYCLE == current CMP.
- MATCH clear: a write to STATUS with wdata[0]=1 clears MATCH.
- Clear/set collision: if a STATUS write with wdata[0]=1 and a match occur in the same cycle, set wins and MATCH stays 1.
- A STATUS write with wdata[0]=0 leaves MATCH unchanged. IEN is loaded from wdata[1] on every STATUS write.
- CMP write: takes effect from the next cycle. The compare in the write cycle uses the old CMP.
- o_timer_irq = MATCH & IEN, taken from registered state with no combinational input path.
- Reset asserted mid-operation: all registers return to their reset values immediately (asynchronously), and RAM keeps its contents. The first CYCLE increment occurs on the first rising edge after i_rst deasserts.

Test Plan:
- RAM write then read: write 32'hDEAD_BEEF to addr 0x010, then read addr 0x010 and 0x013 -> both return DEAD_BEEF. Same-cycle read during the write returns the prior contents.
- Boundary: write 32'h1234_5678 to 0x5FC (last RAM word) -> reads back. Write to 0x610 -> ignored; a read of 0x610 returns 0; RAM word 0x5FC is unchanged.
- Cycle counter: release reset, read 0x600 on the 10th edge-cycle -> returns 9 (first read after deassert returns 0). Write 0x600 -> the value continues counting unaffected.
- Timer match: write CMP=20, STATUS=2 (IEN) -> MATCH and o_timer_irq go high on the edge where CYCLE==20 and stay high. Write STATUS=3 later -> MATCH clears, IRQ drops. Clear in the exact match cycle -> MATCH stays 1.
- GPIO: write 0xA5A5_0F0F to 0x604 -> o_gpio equals it from the next cycle. Assert i_rst asynchronously mid-cycle -> o_gpio=0, o_timer_irq=0, CYCLE=0, CMP=FFFF_FFFF immediately; RAM data written earlier is still readable.
- Wrap: force CMP=0 and run 2^32 cycles (or shorten in sim via a bound-down parameterised check) -> CYCLE wraps to 0 and MATCH sets at wrap.
